// File: rtl/cr16_controller.sv
// -----------------------------------------------------------------------------
// cr16_controller
//
// Multicycle control unit for the CR16 processor. Each instruction is walked
// through FETCH -> DECODE -> (EXEC_R | EXEC_I | MEM_ADR.. | BRJ) -> FETCH, and
// every datapath strobe is decoded from the current state and the IR. The
// controller also owns the architectural flag register used by Bcond/Jcond.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high; returns FSM to FETCH,
//                       clears flags, forces all outputs low while high
//   ir         in  16   current instruction (valid from DECODE onward)
//   alu_flags  in   5   {C,Z,F,L,N} from the ALU
//   mem_ready  in   1   memory completes the current read/write this cycle
//   memread    out  1   memory read request (fetch or load)
//   memwrite   out  1   memory write request (store)
//   ir_mux     out  1   IR load enable
//   pcen       out  1   PC increment enable
//   branch     out  1   take PC-relative branch
//   jump       out  1   load PC from register
//   jal        out  1   write return PC to Rdest
//   regwrt     out  1   register file write enable
//   memtoreg   out  1   write-back source is memory data
//   im_mux     out  1   ALU B operand is immediate
//   pc_mux     out  1   ALU A operand is PC
//   alu_op     out  8   ALU operation code
//   state      out  4   current FSM state (debug)
// -----------------------------------------------------------------------------
module cr16_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic [4:0]  alu_flags,
  input  logic        mem_ready,
  output logic        memread,
  output logic        memwrite,
  output logic        ir_mux,
  output logic        pcen,
  output logic        branch,
  output logic        jump,
  output logic        jal,
  output logic        regwrt,
  output logic        memtoreg,
  output logic        im_mux,
  output logic        pc_mux,
  output logic [7:0]  alu_op,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WB  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BRJ     = 4'd8
  } state_e;

  // Primary opcodes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEMJ  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  // Extended codes under opcode 0100
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_JAL  = 4'b1000;
  localparam logic [3:0] EXT_JCND = 4'b1100;

  // ALU op codes that update the flag register
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_CMP  = 4'b1011;

  // Pass-B operation used to forward the address register in MEM_ADR
  localparam logic [7:0] ALU_PASSB = 8'h0D;

  state_e      state_q, state_d;
  logic [4:0]  flags_q, flags_d;

  logic [3:0]  opcode;
  logic [3:0]  rdest;
  logic [3:0]  ext;
  logic        unused_rsrc;

  assign opcode = ir[15:12];
  assign rdest  = ir[11:8];
  assign ext    = ir[7:4];

  // The rsrc/immediate field is consumed only by the datapath.
  assign unused_rsrc = ^ir[3:0];

  // ALU ops whose result flags become architectural.
  function automatic logic sets_flags(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_CMP);
  endfunction

  // Condition code evaluation on the stored flags {C,Z,F,L,N}.
  function automatic logic cond_true(input logic [3:0] cc, input logic [4:0] f);
    logic c, z, fl, l, n;
    c  = f[4];
    z  = f[3];
    fl = f[2];
    l  = f[1];
    n  = f[0];
    case (cc)
      4'b0000: return z;            // EQ
      4'b0001: return !z;           // NE
      4'b0010: return c;            // CS
      4'b0011: return !c;           // CC
      4'b0100: return l;            // HI
      4'b0110: return n;            // GT
      4'b0111: return !n;           // LE
      4'b1000: return fl;           // FS
      4'b1001: return !fl;          // FC
      4'b1010: return !l && !z;     // LO
      4'b1110: return 1'b1;         // UC
      default: return 1'b0;
    endcase
  endfunction

  // State and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 5'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    memread  = 1'b0;
    memwrite = 1'b0;
    ir_mux   = 1'b0;
    pcen     = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    jal      = 1'b0;
    regwrt   = 1'b0;
    memtoreg = 1'b0;
    im_mux   = 1'b0;
    pc_mux   = 1'b0;
    alu_op   = 8'h00;
    state    = 4'(state_q);

    case (state_q)
      S_FETCH: begin
        // Request stays up while waiting; IR/PC only move on completion.
        memread = 1'b1;
        ir_mux  = mem_ready;
        pcen    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_EXEC_R;
          OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
          OP_SUBI, OP_CMPI, OP_MOVI: state_d = S_EXEC_I;
          OP_MEMJ: begin
            if (ext == EXT_LOAD || ext == EXT_STOR)     state_d = S_MEM_ADR;
            else if (ext == EXT_JCND || ext == EXT_JAL) state_d = S_BRJ;
            else                                        state_d = S_FETCH;
          end
          OP_BCOND: state_d = S_BRJ;
          default:  state_d = S_FETCH;   // NOP / undefined
        endcase
      end

      S_EXEC_R: begin
        alu_op = {4'b0000, ext};
        regwrt = (ext != ALU_CMP);
        if (sets_flags(ext)) flags_d = alu_flags;
        state_d = S_FETCH;
      end

      S_EXEC_I: begin
        alu_op = {4'b0000, opcode};
        im_mux = 1'b1;
        regwrt = (opcode != OP_CMPI);
        if (sets_flags(opcode)) flags_d = alu_flags;
        state_d = S_FETCH;
      end

      S_MEM_ADR: begin
        alu_op  = ALU_PASSB;
        state_d = (ext == EXT_STOR) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        memread = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        regwrt   = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WR: begin
        memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_BRJ: begin
        if (opcode == OP_BCOND) begin
          branch = cond_true(rdest, flags_q);
        end else if (ext == EXT_JAL) begin
          // JAL is unconditional: link and jump through the register.
          jump   = 1'b1;
          jal    = 1'b1;
          regwrt = 1'b1;
          pc_mux = 1'b1;
        end else begin
          jump = cond_true(rdest, flags_q);
        end
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;   // unreachable encodings recover
    endcase

    // Reset silences every output so an aborted instruction never
    // issues a partial write.
    if (reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      ir_mux   = 1'b0;
      pcen     = 1'b0;
      branch   = 1'b0;
      jump     = 1'b0;
      jal      = 1'b0;
      regwrt   = 1'b0;
      memtoreg = 1'b0;
      im_mux   = 1'b0;
      pc_mux   = 1'b0;
      alu_op   = 8'h00;
      state    = 4'd0;
    end
  end

endmodule

// File: doc/cr16_controller.md
# cr16_controller

Multicycle control unit for the CR16 processor. Sits directly upstream of the datapath. Sequences each instruction through fetch, decode, execute and memory states, and drives every datapath control strobe. It also holds the architectural flag register used by conditional branches and jumps. It waits on a memory-ready handshake for instruction fetches, loads and stores.

## Interface
Parameters:
- None; all widths fixed (16-bit instructions, 5 flags, 8-bit ALU op).

Ports:
- clk  in  1  rising-edge clock, single domain
- reset  in  1  synchronous, active-high; returns FSM to FETCH
- ir  in  16  current instruction from datapath IR; valid from DECODE onward
- alu_flags  in  5  ALU flags {C,Z,F,L,N} = [4:0] order C=[4], Z=[3], F=[2], L=[1], N=[0]
- mem_ready  in  1  memory completes current read/write this cycle
- memread  out  1  memory read request (fetch or load)
- memwrite  out  1  memory write request (store)
- ir_mux  out  1  IR load enable
- pcen  out  1  PC increment enable
- branch  out  1  take PC-relative branch
- jump  out  1  load PC from register
- jal  out  1  link: write return PC to Rdest
- regwrt  out  1  register file write enable
- memtoreg  out  1  write-back source is memory data
- im_mux  out  1  ALU B operand is immediate
- pc_mux  out  1  ALU A operand is PC
- alu_op  out  8  ALU operation code
- state  out  4  current FSM state, for debug

## Operation
- Fields: opcode=ir[15:12], rdest=ir[11:8], ext=ir[7:4], rsrc/imm=ir[3:0].
- States: FETCH(0), DECODE(1), EXEC_R(2), EXEC_I(3), MEM_ADR(4), MEM_RD(5), MEM_WB(6), MEM_WR(7), BRJ(8). Encodings 9–15 are unreachable; if entered, go to FETCH.
- FETCH: memread=1. ir_mux=pcen=mem_ready. Advance to DECODE only when mem_ready=1; otherwise hold.
- DECODE decodes the instruction; no strobes are asserted. Next state:
  - opcode 0000 → EXEC_R.
  - opcode in {0001,0010,0011,0101,1001,1011,1101} → EXEC_I.
  - opcode 0100 with ext 0000 (LOAD) or 0100 (STOR) → MEM_ADR.
  - opcode 0100 with ext 1100 (Jcond) or 1000 (JAL) → BRJ.
  - opcode 1100 (Bcond) → BRJ.
  - Anything else is a NOP → FETCH.
- EXEC_R: alu_op={4'b0000,ext}. regwrt=1 unless ext=1011 (CMP). Next FETCH.
- EXEC_I: alu_op={4'b0000,opcode}, im_mux=1. regwrt=1 unless opcode=1011. Next FETCH.
- Flag register: loaded from alu_flags at the end of EXEC_R/EXEC_I only when the op code is ADD 0101, SUB 1001 or CMP 1011. Otherwise it holds its value.
- MEM_ADR: alu_op=8'h0D (pass B = address register). Next MEM_RD for LOAD, MEM_WR for STOR.
- MEM_RD: memread=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: regwrt=1, memtoreg=1. Next FETCH.
- MEM_WR: memwrite=1. Hold until mem_ready, then FETCH.
- BRJ, when the condition is true:
  - Bcond asserts branch=1.
  - Jcond asserts jump=1.
  - JAL asserts jump=1, jal=1, regwrt=1, pc_mux=1 (the JAL condition is always true).
  - Next state is FETCH in every case.
- Condition code rdest, evaluated on the flag register:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - GT 0110: N
  - LE 0111: !N
  - FS 1000: F
  - FC 1001: !F
  - LO 1010: !L & !Z
  - HI 0100: L
  - UC 1110: always
  - All others: never taken
- Outputs not listed for a state are 0. alu_op defaults to 8'h00.

## Timing
- Outputs are Moore functions of state and ir. The exceptions are ir_mux and pcen in FETCH, which also depend on mem_ready.
- Reset is synchronous. While reset=1, every output is forced to 0 combinationally. On the next edge, state=FETCH and the flag register is 5'b0.
- Reset asserted mid-instruction (including MEM_WR waiting on mem_ready) aborts the instruction. No partial regwrt is ever issued after reset.
- Latency with mem_ready always high:
  - ALU/CMP: 3 cycles.
  - Branch/jump/JAL: 3 cycles.
  - STOR: 4 cycles.
  - LOAD: 5 cycles.
  - NOP: 2 cycles.
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle. During the wait, request strobes stay high and nothing else changes.
- Flags written by an instruction are visible to a branch whose DECODE is in the next instruction (no bypass needed).

## Test plan
- **Reset.** Hold reset=1 for 2 cycles from an arbitrary state.
  - During reset, all outputs are 0.
  - After release: state=0, memread=1, and the flag register is 0 (check with BEQ not taken).
- **ADD then CMP.** ir=16'h0152 (ADD), then 16'h01B2 (CMP), mem_ready=1.
  - States cycle 0→1→2 for each.
  - regwrt=1 only for ADD, alu_op=8'h05 then 8'h0B. Each instruction takes 3 cycles.
- **Immediate op.** ir=16'h5107 (ADDI).
  - In EXEC_I: im_mux=1, regwrt=1, alu_op=8'h05.
- **Load with wait states.** ir=16'h4102 (LOAD), mem_ready low for 3 cycles in MEM_RD.
  - memread stays high throughout the wait.
  - MEM_WB follows one cycle after mem_ready rises, with regwrt=memtoreg=1.
  - Total instruction time is 8 cycles.
- **Conditional branch.** CMP sets Z=1 (alu_flags=5'b01000), then BEQ (ir=16'hC005).
  - branch=1 in BRJ.
  - Repeat with Z=0: branch=0, and the PC advanced only by FETCH's pcen.
- **JAL and NOP.** ir=16'h4E8A (JAL), then ir=16'hF000 (illegal).
  - JAL: jump=jal=regwrt=pc_mux=1 in BRJ.
  - Illegal: FETCH→DECODE→FETCH with no strobes asserted in DECODE.
